// File: rtl/seg_scan_capture.sv
// Samples a multiplexed seven-segment bus and recovers the hex value shown at each digit position.
// Scan transitions are debounced; patterns outside the hex set raise a sticky per-position error.
module seg_scan_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [6:0]              segments,
  input  logic [NUM_DIGITS-1:0]   anodes,
  input  logic                    clear_err,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   seg_err,
  output logic                    update,
  output logic [IDX_W-1:0]        update_idx,
  output logic                    frame_done
);

  // state  | meaning
  // IDLE   | no single digit selected
  // SETTLE | one digit selected, waiting for a stable run
  // LOCKED | current sample already captured
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_LOCKED} state_t;

  localparam int RUN_W = $clog2(STABLE_CYCLES + 1);

  state_t                  state_q, state_d;
  logic [6:0]              seg_r_q, seg_p_q;
  logic [NUM_DIGITS-1:0]   an_r_q, an_p_q;
  logic [RUN_W-1:0]        run_q, run_d;
  logic                    changed, an_onehot, run_full, capture;
  logic [IDX_W-1:0]        cap_idx;
  logic [4:0]              dec;

  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic                    update_q, update_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    frame_q, frame_d;

  // Returns {legal, value}; blank and illegal patterns both report legal=0.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    case (seg)
      7'h7E: return 5'h10;
      7'h30: return 5'h11;
      7'h6D: return 5'h12;
      7'h79: return 5'h13;
      7'h33: return 5'h14;
      7'h5B: return 5'h15;
      7'h5F: return 5'h16;
      7'h70: return 5'h17;
      7'h7F: return 5'h18;
      7'h7B: return 5'h19;
      7'h77: return 5'h1A;
      7'h1F: return 5'h1B;
      7'h4E: return 5'h1C;
      7'h3D: return 5'h1D;
      7'h4F: return 5'h1E;
      7'h47: return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seg_r_q <= '0;
      seg_p_q <= '0;
      an_r_q  <= '0;
      an_p_q  <= '0;
      run_q   <= '0;
    end else begin
      seg_r_q <= segments;
      seg_p_q <= seg_r_q;
      an_r_q  <= anodes;
      an_p_q  <= an_r_q;
      run_q   <= run_d;
    end
  end

  always_comb begin
    changed   = (seg_r_q != seg_p_q) || (an_r_q != an_p_q);
    an_onehot = (an_r_q != '0) && ((an_r_q & (an_r_q - 1'b1)) == '0);
    if (changed)
      run_d = RUN_W'(1);
    else if (run_q < RUN_W'(STABLE_CYCLES))
      run_d = run_q + RUN_W'(1);
    else
      run_d = run_q;
    run_full = (run_d == RUN_W'(STABLE_CYCLES));
    cap_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (an_r_q[i]) cap_idx = IDX_W'(i);
    dec = decode_seg(seg_r_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:
        if (an_onehot) state_d = run_full ? ST_LOCKED : ST_SETTLE;
      ST_SETTLE:
        if (!an_onehot)    state_d = ST_IDLE;
        else if (run_full) state_d = ST_LOCKED;
      ST_LOCKED:
        if (changed) begin
          if (!an_onehot)    state_d = ST_IDLE;
          else if (run_full) state_d = ST_LOCKED;
          else               state_d = ST_SETTLE;
        end
      default: state_d = ST_IDLE;
    endcase
  end

  // Only STABLE_CYCLES=1 can reach a full run from LOCKED, and only on a fresh sample.
  always_comb begin
    capture = an_onehot && run_full && ((state_q != ST_LOCKED) || changed);
  end

  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    err_d    = clear_err ? '0 : err_q;
    mask_d   = mask_q;
    update_d = 1'b0;
    idx_d    = idx_q;
    frame_d  = 1'b0;
    if (capture) begin
      update_d = 1'b1;
      idx_d    = cap_idx;
      if (dec[4]) begin
        digits_d[4*int'(cap_idx) +: 4] = dec[3:0];
        valid_d[cap_idx] = 1'b1;
        mask_d[cap_idx]  = 1'b1;
      end else if (seg_r_q == 7'h00) begin
        valid_d[cap_idx] = 1'b0;
        mask_d[cap_idx]  = 1'b1;
      end else begin
        err_d[cap_idx] = 1'b1;
      end
      if (&mask_d) begin
        frame_d = 1'b1;
        mask_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      digits_q <= '0;
      valid_q  <= '0;
      err_q    <= '0;
      mask_q   <= '0;
      update_q <= 1'b0;
      idx_q    <= '0;
      frame_q  <= 1'b0;
    end else begin
      digits_q <= digits_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      mask_q   <= mask_d;
      update_q <= update_d;
      idx_q    <= idx_d;
      frame_q  <= frame_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign seg_err     = err_q;
  assign update      = update_q;
  assign update_idx  = idx_q;
  assign frame_done  = frame_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: directed scenarios plus random scanning, checked every cycle
// against a model that captures on "S identical one-hot samples following a different one".
module tb_seg_scan_capture;
  localparam int N = 4;
  localparam int S = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  segments;
  logic [N-1:0] anodes;
  logic        clear_err;
  logic [4*N-1:0] digits;
  logic [N-1:0] digit_valid, seg_err;
  logic        update, frame_done;
  logic [1:0]  update_idx;

  seg_scan_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk(clk), .reset_n(reset_n), .segments(segments), .anodes(anodes),
    .clear_err(clear_err), .digits(digits), .digit_valid(digit_valid),
    .seg_err(seg_err), .update(update), .update_idx(update_idx),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // reference model state
  logic [6:0] lut [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                           7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  logic [10:0] hist [S+1];
  logic [4*N-1:0] m_digits;
  logic [N-1:0] m_valid, m_err, m_mask;
  logic m_update, m_frame;
  logic [1:0] m_idx;
  int dut_upd = 0;
  int dut_frm = 0;

  function automatic int hex_of(input logic [6:0] p);
    if (p == 7'h00) return -1;
    for (int i = 0; i < 16; i++) if (lut[i] == p) return i;
    return -2;
  endfunction

  task automatic model_step();
    logic [10:0] cur;
    bit stable;
    int p, v;
    if (!reset_n) begin
      for (int i = 0; i <= S; i++) hist[i] = '0;
      m_digits = '0; m_valid = '0; m_err = '0; m_mask = '0;
      m_update = 0; m_frame = 0; m_idx = '0;
      return;
    end
    m_update = 0;
    m_frame = 0;
    if (clear_err) m_err = '0;
    cur = hist[S];
    stable = 1;
    for (int i = 1; i < S; i++) if (hist[i] != cur) stable = 0;
    if (stable && hist[0] != cur && $countones(cur[N-1:0]) == 1) begin
      p = 0;
      for (int i = 0; i < N; i++) if (cur[i]) p = i;
      m_update = 1;
      m_idx = 2'(p);
      v = hex_of(cur[10:4]);
      if (v >= 0) begin
        m_digits[4*p +: 4] = 4'(v);
        m_valid[p] = 1'b1;
        m_mask[p] = 1'b1;
      end else if (v == -1) begin
        m_valid[p] = 1'b0;
        m_mask[p] = 1'b1;
      end else begin
        m_err[p] = 1'b1;
      end
      if (&m_mask) begin
        m_frame = 1;
        m_mask = '0;
      end
    end
    for (int i = 0; i < S; i++) hist[i] = hist[i+1];
    hist[S] = {segments, anodes};
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("digits", 32'(digits), 32'(m_digits));
    check("digit_valid", 32'(digit_valid), 32'(m_valid));
    check("seg_err", 32'(seg_err), 32'(m_err));
    check("update", 32'(update), 32'(m_update));
    check("frame_done", 32'(frame_done), 32'(m_frame));
    if (m_update) check("update_idx", 32'(update_idx), 32'(m_idx));
    if (update) dut_upd++;
    if (frame_done) dut_frm++;
  endtask

  task automatic hold(input logic [N-1:0] an, input logic [6:0] seg, input int n);
    anodes = an;
    segments = seg;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int u0, f0, len;
    logic [6:0] seg;
    logic [N-1:0] an;
    reset_n = 0; segments = '0; anodes = '0; clear_err = 0;
    tick(); tick();
    check("reset_digits", 32'(digits), 32'h0);
    check("reset_flags", 32'({digit_valid, seg_err, update, frame_done}), 32'h0);
    reset_n = 1;

    // 1: single digit capture
    u0 = dut_upd;
    hold(4'b0001, 7'h30, 6);
    check("t1_updates", 32'(dut_upd - u0), 32'd1);
    check("t1_digit0", 32'(digits[3:0]), 32'h1);
    check("t1_valid", 32'(digit_valid), 32'b0001);

    // 2: full scan completes a frame
    u0 = dut_upd; f0 = dut_frm;
    hold(4'b0001, 7'h7E, 8);
    hold(4'b0010, 7'h6D, 8);
    hold(4'b0100, 7'h4F, 8);
    hold(4'b1000, 7'h47, 8);
    check("t2_digits", 32'(digits), 32'hFE20);
    check("t2_valid", 32'(digit_valid), 32'hF);
    check("t2_frames", 32'(dut_frm - f0), 32'd1);

    // 3: short glitch restarts the run
    u0 = dut_upd;
    hold(4'b0010, 7'h79, 2);
    hold(4'b0010, 7'h30, 2);
    hold(4'b0010, 7'h79, 8);
    check("t3_updates", 32'(dut_upd - u0), 32'd1);
    check("t3_digit1", 32'(digits[7:4]), 32'h3);

    // 4: illegal pattern, then clear coinciding with a new error
    hold(4'b0100, 7'h01, 8);
    check("t4_err", 32'(seg_err), 32'b0100);
    check("t4_digit2", 32'(digits[11:8]), 32'hE);
    hold(4'b0100, 7'h02, S);
    clear_err = 1;
    tick();
    clear_err = 0;
    check("t4_err_clear_race", 32'(seg_err), 32'b0100);
    clear_err = 1;
    hold(4'b0100, 7'h02, 1);
    clear_err = 0;
    check("t4_err_cleared", 32'(seg_err), 32'b0000);

    // 5: no single digit selected
    u0 = dut_upd;
    hold(4'b0000, 7'h7F, 3);
    hold(4'b0011, 7'h7F, 10);
    check("t5_updates", 32'(dut_upd - u0), 32'd0);

    // 6: reset in the middle of a settle
    u0 = dut_upd;
    hold(4'b0010, 7'h5B, 3);
    reset_n = 0;
    tick();
    check("t6_updates", 32'(dut_upd - u0), 32'd0);
    check("t6_outputs", 32'({digits, digit_valid, seg_err, update, frame_done}), 32'h0);
    reset_n = 1;
    for (int k = 1; k <= S + 1; k++) begin
      tick();
      check("t6_relatch", 32'(update), (k == S + 1) ? 32'd1 : 32'd0);
    end
    check("t6_digit1", 32'(digits[7:4]), 32'h5);

    // random scanning
    for (int r = 0; r < 400; r++) begin
      case ($urandom_range(9))
        0:       an = '0;
        1:       an = N'($urandom);
        default: an = N'(1) << $urandom_range(N-1);
      endcase
      case ($urandom_range(9))
        0, 1, 2: seg = 7'($urandom);
        3:       seg = 7'h00;
        default: seg = lut[$urandom_range(15)];
      endcase
      anodes = an;
      segments = seg;
      len = $urandom_range(8, 1);
      for (int i = 0; i < len; i++) begin
        clear_err = ($urandom_range(15) == 0);
        reset_n = ($urandom_range(199) != 0);
        tick();
      end
      clear_err = 0;
      reset_n = 1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
